// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch buffer: 8-halfword queue feeding a 48-bit F-stage window
// Optional macro FETCH_BUF_PERF_EN adds the starve_cnt performance counter output.
module fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        consume,
  input  logic [1:0]  consume_len,
  output logic        win_valid,
  output logic [31:0] win_pc,
  output logic        win_mode,
  output logic [2:0]  win_off,
  output logic [47:0] win_inst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
`ifdef FETCH_BUF_PERF_EN
  ,
  output logic [31:0] starve_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t      state;
  logic [15:0] q [8];
  logic [2:0]  head;
  logic [3:0]  count;
  logic [31:0] fa;
  logic        skip;

  logic [1:0]  cons_n;
  logic [1:0]  fill_n;
  logic        take;
  logic [3:0]  count_after;
  logic        space_ok;
  logic [2:0]  tail;
  logic [2:0]  tail_p1;
  logic [31:0] tgt_fa;

  // A redirect kills any data arriving in the same cycle, so it never counts as a fill.
  always_comb begin
    cons_n      = (consume && win_valid) ? consume_len : 2'd0;
    take        = (state == S_REQ) && imem_ack && !redirect;
    fill_n      = take ? (skip ? 2'd1 : 2'd2) : 2'd0;
    count_after = count - {2'b00, cons_n} + {2'b00, fill_n};
    space_ok    = (count_after <= 4'd6);
    tail        = head + count[2:0];
    tail_p1     = tail + 3'd1;
    tgt_fa      = {redirect_pc[31:2], 2'b00};
  end

  assign win_valid = (count >= 4'd3);
  assign win_off   = win_pc[2:0];
  assign win_inst  = {q[head], q[head + 3'd1], q[head + 3'd2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0;
      count     <= 4'd0;
      head      <= 3'd0;
      win_pc    <= RESET_PC;
      win_mode  <= 1'b0;
      fa        <= {RESET_PC[31:2], 2'b00};
      skip      <= RESET_PC[1];
      for (int i = 0; i < 8; i++) q[i] <= 16'h0;
    end else if (redirect) begin
      count    <= 4'd0;
      win_pc   <= {redirect_pc[31:1], 1'b0};
      win_mode <= redirect_pc[0];
      skip     <= redirect_pc[1];
      fa       <= tgt_fa;
      // An outstanding request cannot be withdrawn; wait out its ack in DROP.
      if (state != S_IDLE && !imem_ack) begin
        state <= S_DROP;
      end else begin
        state     <= S_REQ;
        imem_req  <= 1'b1;
        imem_addr <= tgt_fa;
      end
    end else begin
      count  <= count_after;
      head   <= head + {1'b0, cons_n};
      win_pc <= win_pc + {29'd0, cons_n, 1'b0};
      case (state)
        S_IDLE: begin
          if (space_ok) begin
            state     <= S_REQ;
            imem_req  <= 1'b1;
            imem_addr <= fa;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            if (skip) begin
              q[tail] <= imem_rdata[15:0];
            end else begin
              q[tail]    <= imem_rdata[31:16];
              q[tail_p1] <= imem_rdata[15:0];
            end
            skip <= 1'b0;
            fa   <= fa + 32'd4;
            if (space_ok) begin
              imem_addr <= fa + 32'd4;
            end else begin
              state    <= S_IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            state     <= S_REQ;
            imem_addr <= fa;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_BUF_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 32'h0;
    end else if (!win_valid && !redirect) begin
      starve_cnt <= starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - scoreboard bench for fetch_buffer against an address-level window model
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        consume = 1'b0;
  logic [1:0]  consume_len = 2'd0;
  logic        win_valid;
  logic [31:0] win_pc;
  logic        win_mode;
  logic [2:0]  win_off;
  logic [47:0] win_inst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
`ifdef FETCH_BUF_PERF_EN
  logic [31:0] starve_cnt;
  logic [31:0] starve_mark;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        mode;
    logic [47:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc = 32'h100;
  logic        model_mode = 1'b0;
  int          lat_mode = 0;
  int          wait_left = 0;
  bit          in_txn = 0;
  bit          waited = 0;
  logic [31:0] txn_addr = 32'h0;

  always #5 clk = ~clk;

  fetch_buffer #(.RESET_PC(32'h100)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .consume     (consume),
    .consume_len (consume_len),
    .win_valid   (win_valid),
    .win_pc      (win_pc),
    .win_mode    (win_mode),
    .win_off     (win_off),
    .win_inst    (win_inst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata)
`ifdef FETCH_BUF_PERF_EN
    ,
    .starve_cnt  (starve_cnt)
`endif
  );

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [15:0] m;
    m = a[16:1] * 16'h9e37;
    return m + a[31:16] + 16'h1234;
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return {hw(a), hw(a + 32'd2)};
  endfunction

  function automatic logic [47:0] win_of(input logic [31:0] pc);
    return {hw(pc), hw(pc + 32'd2), hw(pc + 32'd4)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory: one request at a time, ack after lat_mode wait cycles (random 0..3 when negative).
  always @(negedge clk) begin
    if (reset) begin
      imem_ack  = 1'b0;
      in_txn    = 0;
      wait_left = 0;
    end else if (imem_req) begin
      if (!in_txn) begin
        in_txn    = 1;
        waited    = 0;
        txn_addr  = imem_addr;
        wait_left = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end
      if (wait_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = word(imem_addr);
        in_txn     = 0;
        if (waited) chk("addr_stable", imem_addr, txn_addr);
      end else begin
        imem_ack = 1'b0;
        waited   = 1;
        wait_left--;
      end
    end else begin
      imem_ack = 1'b0;
    end
  end

  // Monitor: every accepted window is compared with the oldest expected entry.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #1;
    if (!reset && !redirect && consume && consume_len != 2'd0 && win_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: window accepted at %0h with no expected entry", win_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", win_pc, e.pc);
        chk("sb_mode", win_mode, e.mode);
        chk("sb_off", win_off, e.pc[2:0]);
        chk("sb_inst", win_inst, e.inst);
      end
    end
  end

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    consume     = 1'b0;
    model_pc    = {pc[31:1], 1'b0};
    model_mode  = pc[0];
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic do_consume(input logic [1:0] len);
    int n = 0;
    while (!win_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!win_valid) begin
      checks++;
      errors++;
      $display("FAIL consume_timeout: win_valid got 0 expected 1");
    end else begin
      consume     = 1'b1;
      consume_len = len;
      exp_q.push_back('{model_pc, model_mode, win_of(model_pc)});
      model_pc = model_pc + {29'd0, len, 1'b0};
      @(negedge clk);
      consume = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          found;
    int          got;
    int          r;
    logic [31:0] pc;

    lat_mode = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", win_valid, 0);
    chk("rst_pc", win_pc, 32'h100);
    chk("rst_mode", win_mode, 0);
    chk("rst_off", win_off, 0);
    reset = 1'b0;

    @(negedge clk);
    chk("boot_req0", imem_req, 1);
    chk("boot_addr0", imem_addr, 32'h100);
    chk("boot_valid0", win_valid, 0);
    @(negedge clk);
    chk("boot_addr1", imem_addr, 32'h104);
    chk("boot_valid1", win_valid, 0);
    @(negedge clk);
    chk("boot_valid2", win_valid, 1);
    chk("boot_pc", win_pc, 32'h100);
    chk("boot_inst", win_inst, win_of(32'h100));

    do_consume(2'd1);
    chk("steady_pc1", win_pc, 32'h102);
    do_consume(2'd2);
    chk("steady_pc2", win_pc, 32'h106);
    do_consume(2'd3);
    chk("steady_pc3", win_pc, 32'h10c);

    do_redirect(32'h2003);
    chk("unal_addr", imem_addr, 32'h2000);
    chk("unal_req", imem_req, 1);
    chk("unal_pc", win_pc, 32'h2002);
    chk("unal_mode", win_mode, 1);
    chk("unal_off", win_off, 3'd2);
    @(negedge clk);
    chk("unal_valid_n1", win_valid, 0);
    @(negedge clk);
    chk("unal_valid_n2", win_valid, 1);
    do_consume(2'd3);

    // Redirect lands together with an ack and a consume.
    do_redirect(32'h5000);
    @(negedge clk);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h4000;
    consume     = 1'b1;
    consume_len = 2'd2;
    model_pc    = 32'h4000;
    model_mode  = 1'b0;
    #2;
    chk("coinc_ack", imem_ack, 1);
    chk("coinc_valid", win_valid, 1);
    @(negedge clk);
    redirect = 1'b0;
    consume  = 1'b0;
    chk("coinc_cnt0", win_valid, 0);
    chk("coinc_pc", win_pc, 32'h4000);
    chk("coinc_addr", imem_addr, 32'h4000);
    @(negedge clk);
    chk("coinc_cnt2", win_valid, 0);
    do_consume(2'd2);

    // Fill to 8 with no consume, then check the space rule at 7 and 6.
    do_redirect(32'h6000);
    repeat (5) @(negedge clk);
    chk("full_req", imem_req, 0);
    chk("full_valid", win_valid, 1);
    do_consume(2'd1);
    chk("full7_req", imem_req, 0);
    do_consume(2'd1);
    chk("full6_req", imem_req, 1);
    chk("full6_addr", imem_addr, 32'h6010);

`ifdef FETCH_BUF_PERF_EN
    starve_mark = starve_cnt;
`endif
    do_redirect(32'hFFFF_FFFC);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr1", imem_addr, 32'h0);
    @(negedge clk);
    chk("wrap_valid", win_valid, 1);
    chk("wrap_inst", win_inst, {hw(32'hFFFF_FFFC), hw(32'hFFFF_FFFE), hw(32'h0)});
`ifdef FETCH_BUF_PERF_EN
    chk("wrap_starve", starve_cnt - starve_mark, 32'd2);
`endif
    do_consume(2'd3);

    // Reset mid-run, then redirect while a slow request to 0x108 is outstanding.
    reset      = 1'b1;
    lat_mode   = 3;
    model_pc   = 32'h100;
    model_mode = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    found = 0;
    for (int k = 0; k < 60 && found == 0; k++) begin
      @(negedge clk);
      #2;
      if (imem_req && imem_addr == 32'h108 && !imem_ack) found = 1;
    end
    chk("pend_found", found, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h3000;
    model_pc    = 32'h3000;
    model_mode  = 1'b0;
    @(negedge clk);
    redirect = 1'b0;
    got = 0;
    for (int k = 0; k < 12 && got == 0; k++) begin
      #2;
      chk("pend_addr", imem_addr, 32'h108);
      chk("pend_req", imem_req, 1);
      if (imem_ack) got = 1;
      @(negedge clk);
    end
    chk("pend_ack_seen", got, 1);
    #2;
    chk("retarget_addr", imem_addr, 32'h3000);
    chk("retarget_req", imem_req, 1);
    @(negedge clk);
    do_consume(2'd3);

    lat_mode = -1;
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
        redirect    = 1'b1;
        redirect_pc = pc;
        consume     = 1'($urandom_range(0, 1));
        consume_len = 2'($urandom_range(1, 3));
        model_pc    = {pc[31:1], 1'b0};
        model_mode  = pc[0];
        @(negedge clk);
        redirect = 1'b0;
        consume  = 1'b0;
      end else if (r < 60 && win_valid) begin
        do_consume(2'($urandom_range(1, 3)));
      end else if (r < 65) begin
        consume     = 1'b1;
        consume_len = win_valid ? 2'd0 : 2'($urandom_range(1, 3));
        @(negedge clk);
        consume = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    consume = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
